// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch-mode strobes, default widths.
// Imported by the fetch stage and the controller.
package cpu_pkg;

  localparam int CPU_AW = 8;
  localparam int CPU_RW = 5;
  localparam int CPU_DW = 8;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] LDR = 3'b001;
  localparam logic [2:0] STR = 3'b010;
  localparam logic [2:0] ADD = 3'b011;
  localparam logic [2:0] SUB = 3'b100;
  localparam logic [2:0] JMP = 3'b101;
  localparam logic [2:0] JZ  = 3'b110;
  localparam logic [2:0] HLT = 3'b111;

  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_P1   = 2'b01;
  localparam logic [1:0] FETCH_P2   = 2'b10;
  localparam logic [1:0] FETCH_ILL  = 2'b11;

endpackage

// File: rtl/ins_fetch_unit_pc_counter.sv
// Program counter: free-running +1 on enable, wraps at 2^AW.
// Optional sticky wrap flag under PC_OVF_FLAG_EN.
module pc_counter #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
`ifdef PC_OVF_FLAG_EN
  output logic          o_wrap,
`endif
  output logic [AW-1:0] o_count
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_count <= '0;
    end else if (i_en) begin
      o_count <= o_count + AW'(1);
    end
  end

`ifdef PC_OVF_FLAG_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_wrap <= 1'b0;
    end else if (i_en && (&o_count)) begin
      o_wrap <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: PC, two-part ROM capture, address bus mux.
// Define PC_OVF_FLAG_EN to expose the sticky PC wrap flag o_pc_ovf.
module ins_fetch_unit
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int RW = CPU_RW,
  parameter int DW = CPU_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_rom_data,
  input  logic          i_rom_ren,
  input  logic [1:0]    i_fetch_mode,
  input  logic          i_pc_en,
  input  logic          i_addr_sel,
  output logic [2:0]    o_ins,
  output logic [RW-1:0] o_reg_addr,
  output logic [AW-1:0] o_mem_addr,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_pc,
`ifdef PC_OVF_FLAG_EN
  output logic          o_pc_ovf,
`endif
  output logic          o_fetch_err
);

  if (DW != 3 + RW || DW < AW) begin : g_bad_widths
    $fatal(1, "ins_fetch_unit: need DW == 3+RW and DW >= AW");
  end

  logic cap_p1;
  logic cap_p2;
  logic bad_fetch;

  pc_counter #(
    .AW(AW)
  ) u_pc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_pc_en),
`ifdef PC_OVF_FLAG_EN
    .o_wrap  (o_pc_ovf),
`endif
    .o_count (o_pc)
  );

  // Items are mutually exclusive; an unqualified strobe is an error.
  always_comb begin
    cap_p1    = 1'b0;
    cap_p2    = 1'b0;
    bad_fetch = 1'b0;
    unique case (1'b1)
      (i_fetch_mode == FETCH_P1 && i_rom_ren): cap_p1 = 1'b1;
      (i_fetch_mode == FETCH_P2 && i_rom_ren): cap_p2 = 1'b1;
      (i_fetch_mode == FETCH_ILL ||
       (i_fetch_mode != FETCH_NONE && !i_rom_ren)): bad_fetch = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_ins      <= NOP;
      o_reg_addr <= '0;
    end else if (cap_p1) begin
      o_ins      <= i_rom_data[DW-1 -: 3];
      o_reg_addr <= i_rom_data[RW-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_mem_addr <= '0;
    end else if (cap_p2) begin
      o_mem_addr <= i_rom_data[AW-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fetch_err <= 1'b0;
    end else if (bad_fetch) begin
      o_fetch_err <= 1'b1;
    end
  end

  // No register stage: ROM sees the PC in the same cycle as the strobe.
  assign o_addr = i_addr_sel ? o_mem_addr : o_pc;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit with a combinational ROM model.
// Works with or without PC_OVF_FLAG_EN.
module tb_ins_fetch_unit;

  logic       clk;
  logic       rst;
  logic [7:0] rom_data;
  logic       rom_ren;
  logic [1:0] fetch_mode;
  logic       pc_en;
  logic       addr_sel;
  logic [2:0] ins;
  logic [4:0] reg_addr;
  logic [7:0] mem_addr;
  logic [7:0] addr;
  logic [7:0] pc;
  logic       fetch_err;
`ifdef PC_OVF_FLAG_EN
  logic       pc_ovf;
`endif

  logic [7:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  ins_fetch_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rom_data   (rom_data),
    .i_rom_ren    (rom_ren),
    .i_fetch_mode (fetch_mode),
    .i_pc_en      (pc_en),
    .i_addr_sel   (addr_sel),
    .o_ins        (ins),
    .o_reg_addr   (reg_addr),
    .o_mem_addr   (mem_addr),
    .o_addr       (addr),
    .o_pc         (pc),
`ifdef PC_OVF_FLAG_EN
    .o_pc_ovf     (pc_ovf),
`endif
    .o_fetch_err  (fetch_err)
  );

  assign rom_data = rom[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rom_ren    = 1'b0;
    fetch_mode = 2'b00;
    pc_en      = 1'b0;
    addr_sel   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_err", 32'(fetch_err), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'b101_00011;
    idle();
    rst = 1'b0;
    #12;
    rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_pc", 32'(pc), 0);
      chk("idle_ins", 32'(ins), 0);
      chk("idle_addr", 32'(addr), 0);
      chk("idle_err", 32'(fetch_err), 0);
    end
    chk("idle_reg", 32'(reg_addr), 0);
    chk("idle_mem", 32'(mem_addr), 0);

    // Part-1 capture, then PC increment
    rom_ren = 1'b1; fetch_mode = 2'b01;
    step();
    idle(); pc_en = 1'b1;
    chk("p1_ins", 32'(ins), 5);
    chk("p1_reg", 32'(reg_addr), 3);
    chk("p1_pc0", 32'(pc), 0);
    step();
    idle();
    chk("p1_pc1", 32'(pc), 1);

    // Two-part long op
    do_reset();
    rom[0] = 8'b001_00010;
    rom[1] = 8'h5A;
    rom_ren = 1'b1; fetch_mode = 2'b01; pc_en = 1'b1;
    step();
    chk("lo_ins", 32'(ins), 1);
    chk("lo_pc1", 32'(pc), 1);
    fetch_mode = 2'b10;
    step();
    idle();
    chk("lo_ins2", 32'(ins), 1);
    chk("lo_reg", 32'(reg_addr), 2);
    chk("lo_mem", 32'(mem_addr), 8'h5A);
    chk("lo_pc2", 32'(pc), 2);
    addr_sel = 1'b1;
    #1 chk("lo_addr1", 32'(addr), 8'h5A);
    addr_sel = 1'b0;
    #1 chk("lo_addr0", 32'(addr), 2);
    step();
    chk("lo_hold", 32'(mem_addr), 8'h5A);

    // Same-edge capture and increment at PC=7
    do_reset();
    rom[7] = 8'hE0;
    pc_en = 1'b1;
    repeat (7) step();
    chk("se_pc7", 32'(pc), 7);
    rom_ren = 1'b1; fetch_mode = 2'b01;
    step();
    idle();
    chk("se_ins", 32'(ins), 7);
    chk("se_reg", 32'(reg_addr), 0);
    chk("se_pc8", 32'(pc), 8);

    // Illegal mode, stickiness, clear by reset
    rom_ren = 1'b1; fetch_mode = 2'b11;
    step();
    idle();
    chk("e11_err", 32'(fetch_err), 1);
    chk("e11_ins", 32'(ins), 7);
    chk("e11_mem", 32'(mem_addr), 0);
    step();
    chk("e11_sticky", 32'(fetch_err), 1);
    chk("e11_pc", 32'(pc), 8);
    do_reset();
    chk("e_clr", 32'(fetch_err), 0);
    rom[0] = 8'hFF;
    fetch_mode = 2'b01;
    step();
    idle();
    chk("eren_err", 32'(fetch_err), 1);
    chk("eren_ins", 32'(ins), 0);
    chk("eren_reg", 32'(reg_addr), 0);
    fetch_mode = 2'b10;
    step();
    idle();
    chk("eren_mem", 32'(mem_addr), 0);

    // PC wrap over 256 increments
    do_reset();
    pc_en = 1'b1;
    repeat (255) step();
    chk("wr_pc255", 32'(pc), 255);
`ifdef PC_OVF_FLAG_EN
    chk("wr_ovf0", 32'(pc_ovf), 0);
`endif
    step();
    idle();
    chk("wr_pc0", 32'(pc), 0);
`ifdef PC_OVF_FLAG_EN
    chk("wr_ovf1", 32'(pc_ovf), 1);
    step();
    chk("wr_ovfst", 32'(pc_ovf), 1);
`endif

    // Asynchronous reset mid-instruction
    rom[0] = 8'hC7; rom[1] = 8'h33;
    rom_ren = 1'b1; fetch_mode = 2'b01; pc_en = 1'b1;
    step();
    fetch_mode = 2'b10;
    step();
    fetch_mode = 2'b11;
    step();
    chk("mr_ins", 32'(ins), 6);
    chk("mr_mem", 32'(mem_addr), 8'h33);
    #2 rst = 1'b0;
    #1;
    chk("ar_pc", 32'(pc), 0);
    chk("ar_ins", 32'(ins), 0);
    chk("ar_reg", 32'(reg_addr), 0);
    chk("ar_mem", 32'(mem_addr), 0);
    chk("ar_err", 32'(fetch_err), 0);
    chk("ar_addr", 32'(addr), 0);
`ifdef PC_OVF_FLAG_EN
    chk("ar_ovf", 32'(pc_ovf), 0);
`endif
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar_hold", 32'(pc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
